// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle for both requester ports plus the shared data-memory side.
interface dmem_arbiter_if;
  logic        p0_valid;
  logic        p0_ready;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_we;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_valid;
  logic        p1_ready;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_we;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_d;
  logic [3:0]  mem_we;
  logic [31:0] mem_q;
  modport master (
    output p0_valid, p0_addr, p0_wdata, p0_we, p1_valid, p1_addr, p1_wdata, p1_we, mem_q,
    input  p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata, mem_addr, mem_d, mem_we
  );
  modport slave (
    input  p0_valid, p0_addr, p0_wdata, p0_we, p1_valid, p1_addr, p1_wdata, p1_we, mem_q,
    output p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata, mem_addr, mem_d, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between CPU (port 0) and DMA/debug (port 1).
// Define DMEM_ARB_RR_EN for round-robin instead of fixed port-0 priority.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  logic g0, g1, force0, force1, resp_pend, resp_port;
  logic [CNT_W-1:0] wait_cnt0, wait_cnt1;
`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;
`endif
  always_comb begin
    force0 = wait_cnt0 == LIM;
    force1 = wait_cnt1 == LIM;
`ifdef DMEM_ARB_RR_EN
    g1 = !rst && bus.p1_valid && (!bus.p0_valid || (!force0 && (force1 || rr_ptr)));
`else
    g1 = !rst && bus.p1_valid && (!bus.p0_valid || (!force0 && force1));
`endif
    g0 = !rst && bus.p0_valid && !g1;
  end
  assign bus.p0_ready  = g0;
  assign bus.p1_ready  = g1;
  assign bus.mem_addr  = g0 ? bus.p0_addr  : g1 ? bus.p1_addr  : '0;
  assign bus.mem_d     = g0 ? bus.p0_wdata : g1 ? bus.p1_wdata : '0;
  assign bus.mem_we    = g0 ? bus.p0_we    : g1 ? bus.p1_we    : '0;
  assign bus.p0_rvalid = resp_pend && !resp_port;
  assign bus.p1_rvalid = resp_pend && resp_port;
  assign bus.p0_rdata  = bus.p0_rvalid ? bus.mem_q : '0;
  assign bus.p1_rdata  = bus.p1_rvalid ? bus.mem_q : '0;
  // A counter only ages while its port is actively being refused.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp_pend <= 1'b0;
      resp_port <= 1'b0;
      wait_cnt0 <= '0;
      wait_cnt1 <= '0;
    end else begin
      resp_pend <= g0 || g1;
      resp_port <= g1;
      wait_cnt0 <= (!bus.p0_valid || g0) ? '0 : force0 ? LIM : wait_cnt0 + 1'b1;
      wait_cnt1 <= (!bus.p1_valid || g1) ? '0 : force1 ? LIM : wait_cnt1 + 1'b1;
    end
`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= 1'b0;
    else if (bus.p0_valid && bus.p1_valid) rr_ptr <= g0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small byte-lane memory model.
module tb_dmem_arbiter;
  logic clk, rst;
  int vec, errs;
  logic [31:0] mem [16];
  dmem_arbiter_if bus ();
  dmem_arbiter #(.STARVE_LIMIT(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    automatic logic [31:0] w = mem[bus.mem_addr[3:0]];
    for (int b = 0; b < 4; b++) if (bus.mem_we[b]) w[b*8 +: 8] = bus.mem_d[b*8 +: 8];
    if (bus.mem_we != 4'b0) mem[bus.mem_addr[3:0]] <= w;
    bus.mem_q <= w;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.p0_valid = 0; bus.p0_addr = 0; bus.p0_wdata = 0; bus.p0_we = 0;
    bus.p1_valid = 0; bus.p1_addr = 0; bus.p1_wdata = 0; bus.p1_we = 0;
  endtask
  task automatic test_reset();
    idle();
    rst = 1;
    bus.p0_valid = 1; bus.p0_addr = 5;
    #3;
    vec++; if (bus.p0_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", bus.p0_ready); end
    vec++; if (bus.mem_we !== 4'b0) begin errs++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we); end
    step(); step();
    vec++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid got %b%b exp 00", bus.p0_rvalid, bus.p1_rvalid); end
    rst = 0;
    #4;
    vec++; if (bus.p0_ready !== 1'b1) begin errs++; $display("FAIL inflight_ready got %b exp 1", bus.p0_ready); end
    step();
    idle();
    #1;
    vec++; if (bus.p0_rvalid !== 1'b1) begin errs++; $display("FAIL inflight_rvalid got %b exp 1", bus.p0_rvalid); end
    rst = 1;
    #1;
    vec++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin errs++; $display("FAIL async_drop got %b%b exp 00", bus.p0_rvalid, bus.p1_rvalid); end
    vec++; if (bus.mem_we !== 4'b0) begin errs++; $display("FAIL async_mem_we got %b exp 0", bus.mem_we); end
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin errs++; $display("FAIL post_reset_rvalid got %b%b exp 00", bus.p0_rvalid, bus.p1_rvalid); end
    end
    vec++; if (bus.mem_addr !== 32'h0 || bus.mem_d !== 32'h0 || bus.mem_we !== 4'h0) begin errs++; $display("FAIL idle_mem got %h %h %b exp 0 0 0", bus.mem_addr, bus.mem_d, bus.mem_we); end
  endtask
  task automatic test_p0_read();
    bus.p0_valid = 1; bus.p0_addr = 5;
    #4;
    vec++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) begin errs++; $display("FAIL p0_read_ready got %b%b exp 10", bus.p0_ready, bus.p1_ready); end
    vec++; if (bus.mem_addr !== 32'd5 || bus.mem_we !== 4'b0) begin errs++; $display("FAIL p0_read_mem got %h %b exp 5 0", bus.mem_addr, bus.mem_we); end
    step();
    idle();
    #4;
    vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL p0_read_resp got %b %h exp 1 deadbeef", bus.p0_rvalid, bus.p0_rdata); end
    vec++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 32'h0) begin errs++; $display("FAIL p0_read_other got %b %h exp 0 0", bus.p1_rvalid, bus.p1_rdata); end
    step();
  endtask
  task automatic test_byte_write();
    bus.p1_valid = 1; bus.p1_addr = 7; bus.p1_we = 4'b0100; bus.p1_wdata = 32'h00AA0000;
    #4;
    vec++; if (bus.p1_ready !== 1'b1 || bus.mem_we !== 4'b0100 || bus.mem_d !== 32'h00AA0000) begin errs++; $display("FAIL p1_write_grant got %b %b %h exp 1 0100 00aa0000", bus.p1_ready, bus.mem_we, bus.mem_d); end
    step();
    idle();
    bus.p0_valid = 1; bus.p0_addr = 7;
    #4;
    vec++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 32'h11AA3344) begin errs++; $display("FAIL p1_write_resp got %b %h exp 1 11aa3344", bus.p1_rvalid, bus.p1_rdata); end
    vec++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0) begin errs++; $display("FAIL p1_write_other got %b %h exp 0 0", bus.p0_rvalid, bus.p0_rdata); end
    step();
    idle();
    #4;
    vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h11AA3344) begin errs++; $display("FAIL p0_readback got %b %h exp 1 11aa3344", bus.p0_rvalid, bus.p0_rdata); end
    step();
  endtask
  task automatic test_contention();
    bit e, pe;
    pe = 0;
    bus.p0_valid = 1; bus.p0_addr = 5;
    bus.p1_valid = 1; bus.p1_addr = 7;
    for (int i = 0; i < 20; i++) begin
`ifdef DMEM_ARB_RR_EN
      e = (i % 2) == 1;
`else
      e = (i % 9) == 8;
`endif
      #4;
      vec++; if (bus.p0_ready !== !e || bus.p1_ready !== e) begin errs++; $display("FAIL contention_grant[%0d] got %b%b exp %b%b", i, bus.p0_ready, bus.p1_ready, !e, e); end
      if (i > 0) begin
        vec++; if (bus.p0_rvalid !== !pe || bus.p1_rvalid !== pe) begin errs++; $display("FAIL contention_rvalid[%0d] got %b%b exp %b%b", i, bus.p0_rvalid, bus.p1_rvalid, !pe, pe); end
        vec++; if ((pe ? bus.p1_rdata : bus.p0_rdata) !== (pe ? 32'h11AA3344 : 32'hDEADBEEF)) begin errs++; $display("FAIL contention_rdata[%0d] got %h/%h", i, bus.p0_rdata, bus.p1_rdata); end
      end
      pe = e;
      step();
    end
    idle();
    #4;
    vec++; if (bus.p0_rvalid !== !pe || bus.p1_rvalid !== pe) begin errs++; $display("FAIL contention_last got %b%b exp %b%b", bus.p0_rvalid, bus.p1_rvalid, !pe, pe); end
    step();
  endtask
  task automatic test_back_to_back();
    bus.p0_valid = 1; bus.p0_addr = 3; bus.p0_we = 4'b1111; bus.p0_wdata = 32'h1;
    #4;
    vec++; if (bus.p0_ready !== 1'b1 || bus.mem_we !== 4'b1111) begin errs++; $display("FAIL b2b_write got %b %b exp 1 1111", bus.p0_ready, bus.mem_we); end
    step();
    bus.p0_we = 0; bus.p0_wdata = 0;
    #4;
    vec++; if (bus.p0_ready !== 1'b1 || bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h1) begin errs++; $display("FAIL b2b_wresp got %b %b %h exp 1 1 1", bus.p0_ready, bus.p0_rvalid, bus.p0_rdata); end
    step();
    idle();
    #4;
    vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h1) begin errs++; $display("FAIL b2b_rresp got %b %h exp 1 1", bus.p0_rvalid, bus.p0_rdata); end
    step();
    #4;
    vec++; if (bus.p0_rvalid !== 1'b0) begin errs++; $display("FAIL b2b_quiet got %b exp 0", bus.p0_rvalid); end
    step();
  endtask
  initial begin
    vec = 0; errs = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;
    mem[7] = 32'h11223344;
    test_reset();
    test_p0_read();
    test_byte_write();
    test_contention();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory (word-indexed, 4-bit byte write enables, 1-cycle registered read/write-merge output) between the CPU load/store path (port 0) and a DMA/debug loader (port 1).
- Accepts at most one request per cycle and routes the memory's registered output back to the issuing port.
- Includes a starvation guard so the low-priority port always makes progress.

Parameters:
- STARVE_LIMIT, 8: consecutive stalled cycles after which a waiting port gets forced priority (1..255).
- CNT_W, 8: width of the per-port wait counters.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- p0_valid  input  1  port 0 request valid
- p0_ready  output  1  port 0 request accepted this cycle
- p0_addr  input  32  port 0 word index
- p0_wdata  input  32  port 0 write data, byte lanes pre-shifted
- p0_we  input  4  port 0 byte write enables (0 = read)
- p0_rvalid  output  1  port 0 response valid
- p0_rdata  output  32  port 0 response data
- p1_valid, p1_ready, p1_addr, p1_wdata, p1_we, p1_rvalid, p1_rdata: same as port 0, for port 1
- mem_addr  output  32  to memory address
- mem_d  output  32  to memory write data
- mem_we  output  4  to memory byte write enables
- mem_q  input  32  from memory registered output

Behaviour:
- Reset (async, rst=1): resp_pend=0, resp_port=0, wait_cnt0/1=0, rr_ptr=0. While rst=1, all pX_ready=0 and pX_rvalid=0. A response in flight when rst asserts is dropped.
- Handshake: a request transfers when pX_valid && pX_ready. pX_ready is combinational. A requester holds addr/wdata/we stable while valid && !ready. The arbiter never retracts ready within a cycle.
- Grant: at most one port gets ready per cycle. With no valid request, mem_addr=0, mem_d=0, mem_we=0 (no spurious writes).
- Mux: the granted port's addr/wdata/we drive mem_* combinationally in the grant cycle.
- Priority (default): port 0 wins when both are valid, unless the starvation override applies.
- Starvation override: wait_cntX increments, saturating at STARVE_LIMIT, each cycle pX_valid && !pX_ready. It clears on grant or when pX_valid=0.
  - If exactly one counter equals STARVE_LIMIT, that port wins.
  - If both equal STARVE_LIMIT, port 0 wins.
- Response: on grant, resp_pend<=1 and resp_port<=granted index; otherwise resp_pend<=0.
  - The next cycle, p[resp_port]_rvalid=1 and p[resp_port]_rdata=mem_q.
  - The other port has rvalid=0 and rdata=0.
- Latency: fixed at 1 cycle from accept to rvalid. Throughput is 1 request/cycle; back-to-back grants to alternating ports are allowed.
- Writes also return rvalid. rdata is the merged word (old bytes plus written bytes), exactly as the memory outputs it.
- Simultaneous response and new grant in the same cycle is legal. The response belongs to the previous cycle's grant.
- Responses are not back-pressured. Requesters must sink rvalid.
- The arbiter does no address range checking. Addresses pass through unmodified.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- When defined: replaces fixed priority with round-robin. rr_ptr names the preferred port when both are valid, and toggles to the other port after every grant made while both were valid. The starvation override still takes precedence.
- When undefined: fixed port-0 priority. rr_ptr is not instantiated.

Test Plan:
- Reset then idle: rst=1 pulse mid-run with a read in flight -> p0_rvalid/p1_rvalid drop to 0 immediately; mem_we=0; no response after rst releases.
- Port 0 read alone: mem preloaded word 5=32'hDEADBEEF; p0 read addr 5 -> p0_ready=1 in that cycle, p0_rvalid=1 with rdata=32'hDEADBEEF next cycle, p1_rvalid=0.
- Byte write by port 1: word 7=32'h11223344; p1 we=4'b0100, wdata=32'h00AA0000 -> rdata=32'h11AA3344 next cycle; subsequent p0 read of 7 returns 32'h11AA3344.
- Contention, fixed priority: both valid continuously, STARVE_LIMIT=8 -> p0 granted 8 cycles, p1 granted on the 9th cycle with wait_cnt1 cleared, then p0 resumes; each rvalid goes to the correct port.
- Round-robin (DMEM_ARB_RR_EN): both valid continuously -> grants alternate p0,p1,p0,p1...; p1 never waits more than 1 cycle.
- Back-to-back mixed: p0 write word 3=32'h1 then p0 read word 3 on the next cycle -> read returns 32'h1; the two rvalids occur on consecutive cycles.
